// File: rtl/amber48_pkg.sv
// Shared amber48 constants and the UART transmitter state encoding.
// No logic here. Nothing is registered, so there is no latency or backpressure.
package amber48_pkg;

    localparam int unsigned UART_CLK_HZ = 50_000_000;
    localparam int unsigned UART_BAUD   = 115_200;

    typedef enum logic [1:0] {
        UTX_IDLE,
        UTX_START,
        UTX_DATA,
        UTX_STOP
    } uart_tx_state_e;

endpackage

// File: rtl/amber48_uart_tx_if.sv
// Byte handshake from the dmem UART slot into the transmitter.
// A byte transfers on a cycle where valid and ready are both high. Ready is a level.
interface amber48_uart_tx_if;

    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;

    modport master (output tx_valid, output tx_data, input tx_ready);
    modport slave  (input tx_valid, input tx_data, output tx_ready);

endinterface

// File: rtl/amber48_sync_fifo.sv
// Single-clock FIFO with a power-of-two depth and a show-ahead read port.
// A push becomes visible at the read port one cycle later. A push while full or a pop while empty is dropped.
module amber48_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_dat,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_pop_dat,
    output logic             o_full,
    output logic             o_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push = i_push & ~o_full;
    assign w_pop  = i_pop & ~o_empty;

    // Pointers are exactly log2(DEPTH) wide, so they wrap modulo DEPTH for free.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wr_ptr] <= i_push_dat;
    end

    assign o_pop_dat = r_mem[r_rd_ptr];
    assign o_full    = (r_count == FULL_CNT);
    assign o_empty   = (r_count == '0);

endmodule

// File: rtl/amber48_uart_tx.sv
// 8N1 UART transmitter fed by the dmem byte handshake. Defining AMBER48_UART_TX_FIFO_EN adds a FIFO_DEPTH-entry buffer in front of the shifter.
// Accept-to-start-bit latency is 1 cycle without the buffer and 2 cycles with it. Ready is held low while a frame runs, or while the buffer is full.
module amber48_uart_tx
    import amber48_pkg::*;
#(
    parameter int unsigned CLK_HZ     = UART_CLK_HZ,
    parameter int unsigned BAUD       = UART_BAUD,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    amber48_uart_tx_if.slave   tx_if,
    output logic               tx_o,
    output logic               busy_o
);

    localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int unsigned CNT_W        = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);

    if (CLKS_PER_BIT < 2) begin : g_bad_baud
        $fatal(1, "amber48_uart_tx: CLK_HZ/BAUD must be at least 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $fatal(1, "amber48_uart_tx: FIFO_DEPTH must be a power of two >= 2");
    end

    uart_tx_state_e   r_state;
    uart_tx_state_e   w_state_nxt;
    logic [CNT_W-1:0] r_baud;
    logic [CNT_W-1:0] w_baud_nxt;
    logic [2:0]       r_bit;
    logic [2:0]       w_bit_nxt;
    logic [7:0]       r_shift;
    logic [7:0]       w_shift_nxt;
    logic             r_tx;
    logic             w_tx_nxt;
    logic             r_init;
    logic             w_accept;
    logic             w_bit_end;
    logic             w_src_vld;
    logic [7:0]       w_src_dat;
    logic             w_pending;

    assign w_accept  = tx_if.tx_valid & tx_if.tx_ready;
    assign w_bit_end = (r_baud == BAUD_LAST);

`ifdef AMBER48_UART_TX_FIFO_EN
    logic w_full;
    logic w_empty;
    logic w_pop;

    // Ready only looks at fullness, so a same-cycle pop never frees a slot early.
    assign w_pop = (r_state == UTX_IDLE) & ~w_empty;

    amber48_sync_fifo #(
        .WIDTH (8),
        .DEPTH (int'(FIFO_DEPTH))
    ) u_fifo (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .i_push     (w_accept),
        .i_push_dat (tx_if.tx_data),
        .i_pop      (w_pop),
        .o_pop_dat  (w_src_dat),
        .o_full     (w_full),
        .o_empty    (w_empty)
    );

    assign tx_if.tx_ready = r_init & ~w_full;
    assign w_src_vld      = ~w_empty;
    assign w_pending      = ~w_empty;
`else
    assign tx_if.tx_ready = r_init & (r_state == UTX_IDLE);
    assign w_src_vld      = w_accept;
    assign w_src_dat      = tx_if.tx_data;
    assign w_pending      = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_baud_nxt  = r_baud;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        case (r_state)
            UTX_IDLE: begin
                if (w_src_vld) begin
                    w_state_nxt = UTX_START;
                    w_shift_nxt = w_src_dat;
                    w_baud_nxt  = '0;
                    w_bit_nxt   = '0;
                end
            end
            UTX_START: begin
                if (w_bit_end) begin
                    w_state_nxt = UTX_DATA;
                    w_baud_nxt  = '0;
                end else begin
                    w_baud_nxt  = r_baud + 1'b1;
                end
            end
            UTX_DATA: begin
                if (w_bit_end) begin
                    w_baud_nxt  = '0;
                    w_shift_nxt = {1'b0, r_shift[7:1]};
                    w_bit_nxt   = r_bit + 1'b1;
                    if (r_bit == 3'd7) w_state_nxt = UTX_STOP;
                end else begin
                    w_baud_nxt  = r_baud + 1'b1;
                end
            end
            UTX_STOP: begin
                if (w_bit_end) begin
                    w_state_nxt = UTX_IDLE;
                    w_baud_nxt  = '0;
                end else begin
                    w_baud_nxt  = r_baud + 1'b1;
                end
            end
            default: w_state_nxt = UTX_IDLE;
        endcase

        // The line level is decoded from the next state so the flopped tx lines up with r_state.
        case (w_state_nxt)
            UTX_START: w_tx_nxt = 1'b0;
            UTX_DATA:  w_tx_nxt = w_shift_nxt[0];
            default:   w_tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= UTX_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
            r_init  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_baud  <= w_baud_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            r_tx    <= w_tx_nxt;
            r_init  <= 1'b1;
        end
    end

    assign tx_o   = r_tx;
    assign busy_o = (r_state != UTX_IDLE) | w_pending;

endmodule

// File: tb/tb_amber48_uart_tx.sv
// Directed and random checks of amber48_uart_tx against an ideal 8N1 line model, at 4 clocks per bit.
// The same bench covers both builds, with or without AMBER48_UART_TX_FIFO_EN.
module tb_amber48_uart_tx;

    localparam int CPB   = 4;
    localparam int FRAME = 10 * CPB;
`ifdef AMBER48_UART_TX_FIFO_EN
    localparam int ACC_LAT = 2;
`else
    localparam int ACC_LAT = 1;
`endif

    logic clk_i = 1'b0;
    logic rst_ni;
    logic tx_o;
    logic busy_o;

    amber48_uart_tx_if bus_if ();

    amber48_uart_tx #(
        .CLK_HZ     (400),
        .BAUD       (100),
        .FIFO_DEPTH (4)
    ) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .tx_if  (bus_if),
        .tx_o   (tx_o),
        .busy_o (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    // Per-cycle samples, taken at the falling edge.
    logic       cap_tx[$];
    logic       cap_busy[$];
    logic       cap_rdy[$];
    logic [7:0] exp_b[$];
    int         exp_w[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        cap_tx.push_back(tx_o);
        cap_busy.push_back(busy_o);
        cap_rdy.push_back(bus_if.tx_ready);
        @(negedge clk_i);
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic clear();
        cap_tx.delete();
        cap_busy.delete();
        cap_rdy.delete();
        exp_b.delete();
        exp_w.delete();
    endtask

    task automatic send(input logic [7:0] b);
        int n = 0;
        while (bus_if.tx_ready !== 1'b1 && n < 400) begin
            @(negedge clk_i);
            n++;
        end
        chk("send_ready", 32'(bus_if.tx_ready), 32'd1);
        bus_if.tx_valid = 1'b1;
        bus_if.tx_data  = b;
        tick();
        bus_if.tx_valid = 1'b0;
    endtask

    // Ideal line level s cycles into a frame: start 0, data LSB first, stop 1.
    function automatic logic line_bit(input logic [7:0] b, input int s);
        int k = s / CPB;
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return b[k-1];
    endfunction

    task automatic check_line(input string tag);
        int idx = 0;
        int bad = 0;
        foreach (exp_b[f]) begin
            int w = 0;
            while (idx < cap_tx.size() && cap_tx[idx] === 1'b1) begin
                idx++;
                w++;
            end
            chk({tag, "_idle_before_frame"}, 32'(w), 32'(exp_w[f]));
            if (idx + FRAME > cap_tx.size()) begin
                chk({tag, "_frame_complete"}, 32'd0, 32'd1);
                return;
            end
            for (int s = 0; s < FRAME; s++) begin
                chk({tag, "_line"}, 32'(cap_tx[idx+s]), 32'(line_bit(exp_b[f], s)));
                chk({tag, "_busy_in_frame"}, 32'(cap_busy[idx+s]), 32'd1);
            end
            idx += FRAME;
        end
        if (idx < cap_busy.size()) chk({tag, "_busy_after_stop"}, 32'(cap_busy[idx]), 32'd0);
        else chk({tag, "_tail_captured"}, 32'd0, 32'd1);
        for (int i = idx; i < cap_tx.size(); i++) if (cap_tx[i] !== 1'b1) bad++;
        chk({tag, "_no_extra_frame"}, 32'(bad), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rb;
        int bad;

        bus_if.tx_valid = 1'b0;
        bus_if.tx_data  = '0;
        rst_ni          = 1'b0;
        repeat (3) @(negedge clk_i);

        // Reset state and release.
        chk("rst_tx", 32'(tx_o), 32'd1);
        chk("rst_ready", 32'(bus_if.tx_ready), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        rst_ni = 1'b1;
        #1;
        chk("release_ready_before_edge", 32'(bus_if.tx_ready), 32'd0);
        @(negedge clk_i);
        chk("release_ready_after_edge", 32'(bus_if.tx_ready), 32'd1);
        clear();
        run(5);
        bad = 0;
        foreach (cap_tx[i]) if (cap_tx[i] !== 1'b1 || cap_busy[i] !== 1'b0) bad++;
        chk("idle_after_release", 32'(bad), 32'd0);

        // Single frame 0xA5.
        clear();
        send(8'hA5);
        run(FRAME + 6);
        exp_b.push_back(8'hA5);
        exp_w.push_back(ACC_LAT);
        check_line("a5");
`ifndef AMBER48_UART_TX_FIFO_EN
        bad = 0;
        for (int i = 1; i <= FRAME; i++) if (cap_rdy[i] !== 1'b0) bad++;
        chk("a5_ready_low_40", 32'(bad), 32'd0);
        chk("a5_ready_back", 32'(cap_rdy[FRAME+1]), 32'd1);

        // Valid while not ready is dropped.
        clear();
        send(8'h0F);
        run(3 * CPB);
        chk("ignore_ready_low", 32'(bus_if.tx_ready), 32'd0);
        bus_if.tx_valid = 1'b1;
        bus_if.tx_data  = 8'h33;
        tick();
        bus_if.tx_valid = 1'b0;
        run(FRAME + 20);
        exp_b.push_back(8'h0F);
        exp_w.push_back(ACC_LAT);
        check_line("ignore");
`else
        // Fill a depth-4 buffer on consecutive cycles. The 6th byte is refused.
        clear();
        for (int i = 1; i <= 6; i++) begin
            chk("fifo_ready_per_push", 32'(bus_if.tx_ready), (i <= 5) ? 32'd1 : 32'd0);
            bus_if.tx_valid = 1'b1;
            bus_if.tx_data  = 8'(i);
            tick();
        end
        bus_if.tx_valid = 1'b0;
        run(5 * (FRAME + 1) + 20);
        for (int i = 1; i <= 5; i++) begin
            exp_b.push_back(8'(i));
            exp_w.push_back((i == 1) ? ACC_LAT : 1);
        end
        check_line("fifo_burst");
`endif

        // All-zero and all-one data.
        clear();
        send(8'h00);
        run(FRAME + 4);
        exp_b.push_back(8'h00);
        exp_w.push_back(ACC_LAT);
        check_line("zeros");
        clear();
        send(8'hFF);
        run(FRAME + 4);
        exp_b.push_back(8'hFF);
        exp_w.push_back(ACC_LAT);
        check_line("ones");

        // Random bytes with random idle spacing.
        for (int n = 0; n < 10; n++) begin
            repeat ($urandom_range(0, 5)) @(negedge clk_i);
            rb = 8'($urandom);
            clear();
            send(rb);
            run(FRAME + 3 + int'($urandom_range(0, 3)));
            exp_b.push_back(rb);
            exp_w.push_back(ACC_LAT);
            check_line("random");
        end

        // Reset during data bit 3. With the buffer, two more bytes are waiting.
        clear();
`ifdef AMBER48_UART_TX_FIFO_EN
        bus_if.tx_valid = 1'b1;
        bus_if.tx_data  = 8'h55;
        tick();
        bus_if.tx_data  = 8'hAA;
        tick();
        bus_if.tx_data  = 8'hC3;
        tick();
        bus_if.tx_valid = 1'b0;
`else
        send(8'h55);
`endif
        run(ACC_LAT + 4 * CPB + 1 - cap_tx.size());
        chk("midframe_bit3_low", 32'(tx_o), 32'd0);
        chk("midframe_busy", 32'(busy_o), 32'd1);
        rst_ni = 1'b0;
        #1;
        chk("midframe_rst_tx_async", 32'(tx_o), 32'd1);
        chk("midframe_rst_busy", 32'(busy_o), 32'd0);
        chk("midframe_rst_ready", 32'(bus_if.tx_ready), 32'd0);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        clear();
        run(3 * FRAME);
        bad = 0;
        foreach (cap_tx[i]) if (cap_tx[i] !== 1'b1 || cap_busy[i] !== 1'b0) bad++;
        chk("after_midframe_rst_quiet", 32'(bad), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
